// File: rtl/lot_redraw_scheduler_if.sv
// rtl/lot_redraw_scheduler_if.sv - sensor sample input and VGA/ROM plot output bundle for lot_redraw_scheduler
interface lot_redraw_scheduler_if;
  logic        sample_valid;
  logic [11:0] distance;
  logic [14:0] rom_addr;
  logic        rom_sel;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        plot;
  logic        busy;
  logic        occupied;
  logic        frame_done;

  modport master (
    output sample_valid, distance,
    input  rom_addr, rom_sel, x, y, plot, busy, occupied, frame_done
  );

  modport slave (
    input  sample_valid, distance,
    output rom_addr, rom_sel, x, y, plot, busy, occupied, frame_done
  );
endinterface

// File: rtl/lot_redraw_scheduler.sv
// rtl/lot_redraw_scheduler.sv - debounced occupancy filter driving full-frame background redraws (optional LOT_SENSOR_TIMEOUT_EN)
module lot_redraw_scheduler #(
  parameter logic [11:0] THRESH_CM   = 12'd30,
  parameter logic [11:0] HYST_CM     = 12'd5,
  parameter int          DEBOUNCE_N  = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd3_000_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  lot_redraw_scheduler_if.slave   bus
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_DRAW  = 2'd1;
  localparam logic [1:0]  S_FLUSH = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [14:0] LAST_ADDR = 15'd19199;
  localparam logic [7:0]  X_LAST    = 8'd159;
  localparam logic [12:0] FAR_CM    = {1'b0, THRESH_CM} + {1'b0, HYST_CM};
  localparam logic [3:0]  DEB       = 4'(DEBOUNCE_N);

  logic [1:0]  state_q, state_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        occupied_q, occupied_d;
  logic        shown_q, shown_d;
  logic        init_req_q, init_req_d;
  logic        drawn_sel_q, drawn_sel_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [7:0]  x_cnt_q, x_cnt_d, x_q, x_d;
  logic [6:0]  y_cnt_q, y_cnt_d, y_q, y_d;
  logic        plot_q, plot_d;
  logic        near_w, far_w, qual_w, pend_w;

  assign near_w = bus.distance < THRESH_CM;
  assign far_w  = {1'b0, bus.distance} >= FAR_CM;
  // A sample only counts toward a flip if it argues for the opposite decision
  assign qual_w = occupied_q ? far_w : near_w;
  assign pend_w = (occupied_q != shown_q) || init_req_q;

`ifdef LOT_SENSOR_TIMEOUT_EN
  logic [23:0] silence_q, silence_d;
`endif

  always_comb begin
    run_cnt_d  = run_cnt_q;
    occupied_d = occupied_q;
    if (bus.sample_valid) begin
      if (qual_w) begin
        if (run_cnt_q + 4'd1 == DEB) begin
          occupied_d = ~occupied_q;
          run_cnt_d  = 4'd0;
        end else begin
          run_cnt_d = run_cnt_q + 4'd1;
        end
      end else begin
        run_cnt_d = 4'd0;
      end
    end
`ifdef LOT_SENSOR_TIMEOUT_EN
    silence_d = bus.sample_valid ? 24'd0 : silence_q + 24'd1;
    // A silent sensor is assumed dead and the bay is shown as vacant
    if (!bus.sample_valid && (silence_q + 24'd1 == TIMEOUT_CYC)) begin
      occupied_d = 1'b0;
      run_cnt_d  = 4'd0;
      silence_d  = 24'd0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    shown_d     = shown_q;
    init_req_d  = init_req_q;
    drawn_sel_d = drawn_sel_q;
    rom_addr_d  = rom_addr_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    // Output pixel stage trails the address by one cycle to line up with ROM q
    plot_d      = (state_q == S_DRAW);
    x_d         = (state_q == S_DRAW) ? x_cnt_q : x_q;
    y_d         = (state_q == S_DRAW) ? y_cnt_q : y_q;
    case (state_q)
      S_IDLE: begin
        if (pend_w) begin
          drawn_sel_d = occupied_q;
          rom_addr_d  = 15'd0;
          x_cnt_d     = 8'd0;
          y_cnt_d     = 7'd0;
          state_d     = S_DRAW;
        end
      end
      S_DRAW: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = S_FLUSH;
        end else begin
          rom_addr_d = rom_addr_q + 15'd1;
          if (x_cnt_q == X_LAST) begin
            x_cnt_d = 8'd0;
            y_cnt_d = y_cnt_q + 7'd1;
          end else begin
            x_cnt_d = x_cnt_q + 8'd1;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: begin
        shown_d    = drawn_sel_q;
        init_req_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      run_cnt_q   <= 4'd0;
      occupied_q  <= 1'b0;
      shown_q     <= 1'b0;
      init_req_q  <= 1'b1;
      drawn_sel_q <= 1'b0;
      rom_addr_q  <= 15'd0;
      x_cnt_q     <= 8'd0;
      y_cnt_q     <= 7'd0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      plot_q      <= 1'b0;
`ifdef LOT_SENSOR_TIMEOUT_EN
      silence_q   <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      occupied_q  <= occupied_d;
      shown_q     <= shown_d;
      init_req_q  <= init_req_d;
      drawn_sel_q <= drawn_sel_d;
      rom_addr_q  <= rom_addr_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      plot_q      <= plot_d;
`ifdef LOT_SENSOR_TIMEOUT_EN
      silence_q   <= silence_d;
`endif
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_sel    = drawn_sel_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.occupied   = occupied_q;
  assign bus.frame_done = (state_q == S_DONE);

endmodule
